separable_switch_allocator: RTL and testbench

Input-first separable switch allocator that schedules the router crossbar each cycle. It arbitrates among VCs within each input port, then among input ports contending for each output port. It drives the crossbar's per-output input select (input_vc_sel) plus a valid qualifier, and returns per-VC grants to the input blocks. Both arbitration stages are round-robin with state kept across cycles.

---
 rtl/separable_switch_allocator.sv | 127 ++++++++++++
 tb/tb_separable_switch_allocator.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/separable_switch_allocator.sv
// Input-first separable switch allocator: round-robin VC arbitration per input,
// then round-robin input arbitration per output, with registered grants/selects.
module separable_switch_allocator #(
  parameter int PORT_NUM  = 5,
  parameter int PORT_SIZE = $clog2(PORT_NUM),
  parameter int VC_NUM    = 2,
  parameter int VC_SIZE   = $clog2(VC_NUM)
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]               request_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_SIZE-1:0] out_port_i,
  input  logic [PORT_NUM-1:0]                           downstream_ready_i,
  output logic [PORT_NUM-1:0][VC_NUM-1:0]               vc_grant_o,
  output logic [PORT_NUM-1:0][PORT_SIZE-1:0]            input_vc_sel_o,
  output logic [PORT_NUM-1:0]                           valid_sel_o
);

  localparam int VC_W = (VC_SIZE > 0) ? VC_SIZE : 1;

  logic [PORT_NUM-1:0][VC_NUM-1:0]    elig;
  logic [PORT_NUM-1:0]                cand_vld;
  logic [PORT_NUM-1:0][VC_W-1:0]      cand_vc;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] cand_port;
  logic [PORT_NUM-1:0]                win_vld;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] win_in;

  logic [PORT_NUM-1:0][VC_W-1:0]      vc_ptr_q, vc_ptr_d;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] in_ptr_q, in_ptr_d;
  logic [PORT_NUM-1:0][VC_NUM-1:0]    grant_q, grant_d;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] sel_q, sel_d;
  logic [PORT_NUM-1:0]                valid_q, valid_d;

  // Matching against every legal port index drops out-of-range targets for free.
  always_comb begin
    elig = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        for (int o = 0; o < PORT_NUM; o++) begin
          if (request_i[p][v] && downstream_ready_i[o] &&
              out_port_i[p][v] == PORT_SIZE'(o)) begin
            elig[p][v] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    cand_vld  = '0;
    cand_vc   = '0;
    cand_port = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int k = 0; k < VC_NUM; k++) begin
        int idx;
        idx = (int'(vc_ptr_q[p]) + k) % VC_NUM;
        if (!cand_vld[p] && elig[p][idx]) begin
          cand_vld[p]  = 1'b1;
          cand_vc[p]   = VC_W'(idx);
          cand_port[p] = out_port_i[p][idx];
        end
      end
    end
  end

  always_comb begin
    win_vld = '0;
    win_in  = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int k = 0; k < PORT_NUM; k++) begin
        int idx;
        idx = (int'(in_ptr_q[o]) + k) % PORT_NUM;
        if (!win_vld[o] && cand_vld[idx] && cand_port[idx] == PORT_SIZE'(o)) begin
          win_vld[o] = 1'b1;
          win_in[o]  = PORT_SIZE'(idx);
        end
      end
    end
  end

  // Pointers move only on a final grant so a stage-2 loser keeps its VC priority.
  always_comb begin
    grant_d  = '0;
    sel_d    = '0;
    valid_d  = '0;
    vc_ptr_d = vc_ptr_q;
    in_ptr_d = in_ptr_q;
    for (int o = 0; o < PORT_NUM; o++) begin
      if (win_vld[o]) begin
        valid_d[o]  = 1'b1;
        sel_d[o]    = win_in[o];
        in_ptr_d[o] = PORT_SIZE'((int'(win_in[o]) + 1) % PORT_NUM);
        for (int p = 0; p < PORT_NUM; p++) begin
          if (win_in[o] == PORT_SIZE'(p)) begin
            for (int v = 0; v < VC_NUM; v++) begin
              if (cand_vc[p] == VC_W'(v)) begin
                grant_d[p][v] = 1'b1;
              end
            end
            vc_ptr_d[p] = VC_W'((int'(cand_vc[p]) + 1) % VC_NUM);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vc_ptr_q <= '0;
      in_ptr_q <= '0;
      grant_q  <= '0;
      sel_q    <= '0;
      valid_q  <= '0;
    end else begin
      vc_ptr_q <= vc_ptr_d;
      in_ptr_q <= in_ptr_d;
      grant_q  <= grant_d;
      sel_q    <= sel_d;
      valid_q  <= valid_d;
    end
  end

  assign vc_grant_o     = grant_q;
  assign input_vc_sel_o = sel_q;
  assign valid_sel_o    = valid_q;

endmodule

// File: tb/tb_separable_switch_allocator.sv
// Directed scoreboard bench for separable_switch_allocator (5 ports, 2 VCs).
module tb_separable_switch_allocator;

  localparam int PN = 5;
  localparam int VN = 2;
  localparam int PS = 3;

  logic                       clk = 1'b0;
  logic                       rst = 1'b0;
  logic [PN-1:0][VN-1:0]      request;
  logic [PN-1:0][VN-1:0][PS-1:0] out_port;
  logic [PN-1:0]              ready;
  logic [PN-1:0][VN-1:0]      vc_grant;
  logic [PN-1:0][PS-1:0]      sel;
  logic [PN-1:0]              valid;
  logic [PN-1:0][7:0]         din;

  typedef struct {
    string                 tag;
    logic [PN-1:0][VN-1:0] grant;
    logic [PN-1:0][PS-1:0] sel;
    logic [PN-1:0]         valid;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  separable_switch_allocator #(
    .PORT_NUM(PN), .PORT_SIZE(PS), .VC_NUM(VN), .VC_SIZE(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .request_i(request),
    .out_port_i(out_port),
    .downstream_ready_i(ready),
    .vc_grant_o(vc_grant),
    .input_vc_sel_o(sel),
    .valid_sel_o(valid)
  );

  always #5 clk = ~clk;

  function automatic exp_t none(string tag);
    exp_t e;
    e.tag   = tag;
    e.grant = '0;
    e.sel   = '0;
    e.valid = '0;
    return e;
  endfunction

  function automatic exp_t win(exp_t e, int p, int v, int o);
    exp_t r;
    r = e;
    r.grant[p][v] = 1'b1;
    r.sel[o]      = 3'(p);
    r.valid[o]    = 1'b1;
    return r;
  endfunction

  function automatic logic [7:0] xbar(int o);
    if (valid[o]) return din[sel[o]];
    return 8'h00;
  endfunction

  task automatic check_front();
    exp_t e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 entries expected>=1");
      return;
    end
    e = sb.pop_front();
    n_assert++;
    assert (vc_grant === e.grant) else begin
      n_fail++;
      $error("FAIL %s vc_grant observed=%b expected=%b", e.tag, vc_grant, e.grant);
    end
    n_assert++;
    assert (sel === e.sel) else begin
      n_fail++;
      $error("FAIL %s input_vc_sel observed=%h expected=%h", e.tag, sel, e.sel);
    end
    n_assert++;
    assert (valid === e.valid) else begin
      n_fail++;
      $error("FAIL %s valid_sel observed=%b expected=%b", e.tag, valid, e.valid);
    end
  endtask

  task automatic cycle(exp_t e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_front();
    @(negedge clk);
  endtask

  task automatic clr();
    request  = '0;
    out_port = '0;
    ready    = '1;
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  initial begin
    exp_t e;
    din      = '0;
    rst      = 1'b0;
    request  = 10'($urandom);
    out_port = 30'($urandom);
    ready    = 5'($urandom);
    @(negedge clk);
    repeat (3) cycle(none("reset_hold"));

    clr();
    rst = 1'b1;
    request[2][1]  = 1'b1;
    out_port[2][1] = 3'd4;
    cycle(win(none("first_grant"), 2, 1, 4));
    clr();
    cycle(none("idle"));

    do_reset();
    request[0][0] = 1'b1; out_port[0][0] = 3'd2;
    request[1][0] = 1'b1; out_port[1][0] = 3'd2;
    request[3][0] = 1'b1; out_port[3][0] = 3'd2;
    cycle(win(none("contend_c1"), 0, 0, 2));
    cycle(win(none("contend_c2"), 1, 0, 2));
    cycle(win(none("contend_c3"), 3, 0, 2));
    cycle(win(none("contend_c4"), 0, 0, 2));

    rst = 1'b0;
    #1;
    sb.push_back(none("async_reset"));
    check_front();
    rst = 1'b1;
    cycle(win(none("after_reset"), 0, 0, 2));

    do_reset();
    request[1]     = 2'b11;
    out_port[1][0] = 3'd0;
    out_port[1][1] = 3'd3;
    cycle(win(none("vc_fair_c1"), 1, 0, 0));
    cycle(win(none("vc_fair_c2"), 1, 1, 3));
    cycle(win(none("vc_fair_c3"), 1, 0, 0));

    do_reset();
    request[0]     = 2'b11;
    out_port[0][0] = 3'd1;
    out_port[0][1] = 3'd2;
    ready          = 5'b11101;
    cycle(win(none("backpressure"), 0, 1, 2));
    ready = '1;
    cycle(win(none("ready_raised"), 0, 0, 1));
    ready = '0;
    cycle(none("all_blocked"));

    do_reset();
    request[3][0] = 1'b1; out_port[3][0] = 3'd3;
    cycle(win(none("prime_in_ptr"), 3, 0, 3));
    clr();
    request[0]     = 2'b11;
    out_port[0][0] = 3'd3;
    out_port[0][1] = 3'd1;
    request[4][0]  = 1'b1;
    out_port[4][0] = 3'd3;
    cycle(win(none("s2_loss"), 4, 0, 3));
    cycle(win(none("s2_retry"), 0, 0, 3));
    cycle(win(win(none("s2_both"), 0, 1, 1), 4, 0, 3));

    do_reset();
    request[2]     = 2'b11;
    out_port[2][0] = 3'd5;
    out_port[2][1] = 3'd0;
    cycle(win(none("oor_skip"), 2, 1, 0));
    out_port[2][1] = 3'd7;
    cycle(none("oor_none"));

    do_reset();
    for (int k = 0; k < PN; k++) begin
      e = none("perm");
      for (int p = 0; p < PN; p++) begin
        request[p][0]  = 1'b1;
        out_port[p][0] = 3'((p + k) % PN);
        din[p]         = 8'($urandom);
        e = win(e, p, 0, (p + k) % PN);
      end
      cycle(e);
      for (int p = 0; p < PN; p++) begin
        n_assert++;
        assert (xbar((p + k) % PN) === din[p]) else begin
          n_fail++;
          $error("FAIL perm_data k=%0d out=%0d observed=%h expected=%h",
                 k, (p + k) % PN, xbar((p + k) % PN), din[p]);
        end
      end
    end

    clr();
    cycle(none("all_zero"));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
